// File: rtl/block_unreverse.sv
// Block un-reverser: restores natural order of N-sample blocks that arrive
// newest-first. Two ping-pong banks let one block fill while the other drains.
module block_unreverse #(
   parameter int BITS = 8,
   parameter int N    = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] data_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] data_out,
   output logic            out_last
);

   localparam int            CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   logic [BITS-1:0] mem [2][N];
   logic [1:0]      full;
   logic            wr_bank;
   logic            rd_bank;
   logic [CW-1:0]   wr_cnt;
   logic [CW-1:0]   rd_cnt;
   state_t          state;

   logic            wr_fire;
   logic            load;

   // Write side only looks at its own bank flag; a bank freed this cycle
   // becomes writable on the next one.
   assign in_ready = !reset && !full[wr_bank];
   assign wr_fire  = in_valid && in_ready;
   assign load     = (state == DRAIN) && (!out_valid || out_ready);

   // NOTE: sample storage has no reset; a bank is only read after a whole
   // block has been written into it, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (wr_fire)
         mem[wr_bank][wr_cnt] <= data_in;
   end

   // NOTE: all state here uses non-blocking assignments so every branch sees
   // the flags as they were at the start of the cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         state     <= IDLE;
         out_valid <= 1'b0;
         data_out  <= '0;
         out_last  <= 1'b0;
      end else begin
         if (wr_fire) begin
            if (wr_cnt == LAST_IDX) begin
               wr_cnt        <= '0;
               full[wr_bank] <= 1'b1;
               wr_bank       <= !wr_bank;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (full[rd_bank]) begin
                  rd_cnt <= LAST_IDX;
                  state  <= DRAIN;
               end
            end
            DRAIN: begin
               if (load) begin
                  data_out  <= mem[rd_bank][rd_cnt];
                  out_valid <= 1'b1;
                  out_last  <= (rd_cnt == '0);
                  if (rd_cnt == '0) begin
                     full[rd_bank] <= 1'b0;
                     rd_bank       <= !rd_bank;
                     // Chain straight into the other bank to avoid a bubble.
                     if (full[!rd_bank])
                        rd_cnt <= LAST_IDX;
                     else
                        state <= IDLE;
                  end else begin
                     rd_cnt <= rd_cnt - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (!load && out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            data_out  <= '0;
         end
      end
   end

   stall_hold_a: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable(data_out) && $stable(out_last)));

   last_qualified_a: assert property (@(posedge clk) disable iff (reset)
      out_last |-> out_valid);

endmodule

// File: tb/tb_block_unreverse.sv
// Scoreboard bench for block_unreverse: an N=4 instance for the main tests and
// an N=1 instance for single-sample blocks.
module tb_block_unreverse;

   localparam int BITS = 8;
   localparam int N    = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready, out_valid, out_ready, out_last;
   logic [BITS-1:0] data_in, data_out;
   logic            in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
   logic [BITS-1:0] data_in1, data_out1;

   typedef struct packed {
      logic [BITS-1:0] data;
      logic            last;
   } exp_t;

   exp_t            q4[$];
   exp_t            q1[$];
   logic [BITS-1:0] blk[$];
   exp_t            e4, e1;
   int              checks = 0;
   int              errors = 0;
   bit              rand_rdy = 1'b0;
   logic            stalled = 1'b0;
   logic [BITS-1:0] prev_d;
   logic            prev_l;

   always #5 clk = ~clk;

   block_unreverse #(.BITS(BITS), .N(N)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .out_last(out_last)
   );

   block_unreverse #(.BITS(BITS), .N(1)) dut1 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid1), .in_ready(in_ready1), .data_in(data_in1),
      .out_valid(out_valid1), .out_ready(out_ready1), .data_out(data_out1),
      .out_last(out_last1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [BITS-1:0] d);
      int waited = 0;
      in_valid = 1'b1;
      data_in  = d;
      @(negedge clk);
      while (!in_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'(in_ready), 32'd1);
      end else begin
         blk.push_back(d);
         if (blk.size() == N) begin
            for (int i = N - 1; i >= 0; i--)
               q4.push_back('{data: blk[i], last: (i == 0)});
            blk.delete();
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send1(input logic [BITS-1:0] d);
      int waited = 0;
      in_valid1 = 1'b1;
      data_in1  = d;
      @(negedge clk);
      while (!in_ready1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready1)
         check("in_ready1_timeout", 32'(in_ready1), 32'd1);
      else
         q1.push_back('{data: d, last: 1'b1});
      @(posedge clk);
      #1 in_valid1 = 1'b0;
   endtask

   task automatic wait_drain();
      int waited = 0;
      while ((q4.size() != 0 || q1.size() != 0) && waited < 500) begin
         @(posedge clk);
         waited++;
      end
      check("drain_q4_left", 32'(q4.size()), 32'd0);
      check("drain_q1_left", 32'(q1.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1 out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Output monitor for the N=4 instance: order, last flag and stall stability.
   always @(negedge clk) begin
      if (reset) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(data_out), 32'(prev_d));
            check("stall_last", 32'(out_last), 32'(prev_l));
         end
         if (out_valid && out_ready) begin
            if (q4.size() == 0) begin
               check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               e4 = q4.pop_front();
               check("out_data", 32'(data_out), 32'(e4.data));
               check("out_last", 32'(out_last), 32'(e4.last));
            end
         end
         stalled = out_valid && !out_ready;
         prev_d  = data_out;
         prev_l  = out_last;
      end
   end

   always @(negedge clk) begin
      if (!reset && out_valid1 && out_ready1) begin
         if (q1.size() == 0) begin
            check("unexpected_out1", 32'(out_valid1), 32'd0);
         end else begin
            e1 = q1.pop_front();
            check("out1_data", 32'(data_out1), 32'(e1.data));
            check("out1_last", 32'(out_last1), 32'(e1.last));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      out_ready = 1'b1;
      in_valid1 = 1'b0;
      data_in1  = '0;
      out_ready1 = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_in_ready1", 32'(in_ready1), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Test 1: single block, latency of two clocks from the 4th accept
      for (int v = 1; v <= 4; v++) send(8'(v));
      @(negedge clk);
      check("lat_t0_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_t1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_t2_valid", 32'(out_valid), 32'd1);
      check("lat_t2_data", 32'(data_out), 32'd4);
      @(posedge clk);
      #1;
      wait_drain();

      // Test 2: continuous stream of three blocks
      for (int v = 1; v <= 12; v++) send(8'(v));
      wait_drain();

      // Test 3: consumer stalled, both banks fill and input backs up
      out_ready = 1'b0;
      for (int v = 1; v <= 8; v++) send(8'(v));
      in_valid = 1'b1;
      data_in  = 8'd9;
      repeat (4) begin
         @(negedge clk);
         check("full_in_ready", 32'(in_ready), 32'd0);
         check("full_out_valid", 32'(out_valid), 32'd1);
         check("full_data_out", 32'(data_out), 32'd4);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int v = 9; v <= 12; v++) send(8'(v));
      wait_drain();

      // Test 4: random backpressure
      rand_rdy = 1'b1;
      for (int v = 1; v <= 8; v++) send(8'(v));
      wait_drain();
      rand_rdy = 1'b0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Test 5: reset discards a partial block
      send(8'd1);
      send(8'd2);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst2_in_ready", 32'(in_ready), 32'd0);
      check("rst2_out_valid", 32'(out_valid), 32'd0);
      check("rst2_data_out", 32'(data_out), 32'd0);
      check("rst2_out_last", 32'(out_last), 32'd0);
      blk.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      for (int v = 5; v <= 8; v++) send(8'(v));
      wait_drain();

      // Test 6: N=1 instance, every sample is its own block
      send1(8'hAA);
      send1(8'h55);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
